// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory bus: slave IDs, select width, arbiter states.
package mem_bus_pkg;

  localparam int SLAVE_W = 3;

  localparam logic [SLAVE_W-1:0] DEVICE_1 = 3'd0;
  localparam logic [SLAVE_W-1:0] DEVICE_2 = 3'd1;
  localparam logic [SLAVE_W-1:0] NO_ONE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_hold_timer.sv
// Counts grant cycles that overlap a competing request; flags when the
// holder has used its last allowed overlapping cycle.
module hold_timer #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Expiry is a compare against the last legal count, so the counter never wraps.
  always_comb begin
    expire = (count == CNT_W'(MAX_HOLD - 1));
  end

  // Clear has priority; increment saturates at the expiry value.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-device round-robin memory arbiter with bounded hold and a one-cycle
// NO_ONE gap between grants.
//
// Handshake: a device raises dev_req[i] and keeps it high for the whole
// access. It owns the memory exactly while dev_gnt[i] is high (registered,
// visible one cycle after the request is seen). Dropping dev_req[i] ends the
// access at that edge; the arbiter may also withdraw the grant after
// MAX_HOLD overlapping cycles, in which case the device keeps dev_req high
// and is granted again later. dev_gnt is one-hot or zero.
module mem_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int SLAVE_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              dev_req,
  output logic [1:0]              dev_gnt,
  output logic [SLAVE_W-1:0]      current_slave,
  output logic                    arb_busy,
  output mem_bus_pkg::arb_state_t arb_state
);

  import mem_bus_pkg::*;

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic               gnt_idx;
  logic               gnt_idx_nxt;
  logic               last_gnt;
  logic               winner;
  logic               take_grant;
  logic               other_req;
  logic               expire;
  logic               timer_clr;
  logic [1:0]         gnt_nxt;
  logic [SLAVE_W-1:0] slave_nxt;

  // Round-robin pick: a lone requester wins, a tie goes to the device not granted last.
  always_comb begin
    winner = 1'b0;
    case (dev_req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

  // Competing request from the device that does not hold the grant.
  always_comb begin
    other_req = dev_req[~gnt_idx];
  end

  // Next-state logic: grants always pass through one RELEASE cycle.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|dev_req) begin
          state_nxt  = GRANT;
          take_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!dev_req[gnt_idx] || (other_req && expire)) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (|dev_req) begin
          state_nxt  = GRANT;
          take_grant = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timer runs only while granted and contested; it is cleared on leaving GRANT.
  always_comb begin
    timer_clr = (state != GRANT) || !other_req || (state_nxt != GRANT);
  end

  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (other_req),
    .expire (expire)
  );

  // Next values for the registered grant outputs.
  always_comb begin
    gnt_idx_nxt = take_grant ? winner : gnt_idx;
    gnt_nxt     = 2'b00;
    slave_nxt   = SLAVE_W'(NO_ONE);
    if (state_nxt == GRANT) begin
      gnt_nxt   = gnt_idx_nxt ? 2'b10 : 2'b01;
      slave_nxt = gnt_idx_nxt ? SLAVE_W'(DEVICE_2) : SLAVE_W'(DEVICE_1);
    end
  end

  // State, round-robin history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt_idx       <= 1'b0;
      last_gnt      <= 1'b1;
      dev_gnt       <= 2'b00;
      current_slave <= SLAVE_W'(NO_ONE);
      arb_busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      gnt_idx       <= gnt_idx_nxt;
      if (take_grant) begin
        last_gnt <= winner;
      end
      dev_gnt       <= gnt_nxt;
      current_slave <= slave_nxt;
      arb_busy      <= |gnt_nxt;
    end
  end

  // Debug view of the FSM.
  always_comb begin
    arb_state = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random
// requests and resets, compared against an ownership-level reference model.
module tb_mem_arbiter;

  import mem_bus_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int SW       = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    dev_req = 2'b00;
  logic [1:0]    dev_gnt;
  logic [SW-1:0] current_slave;
  logic          arb_busy;
  arb_state_t    arb_state;

  mem_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .SLAVE_W  (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dev_req       (dev_req),
    .dev_gnt       (dev_gnt),
    .current_slave (current_slave),
    .arb_busy      (arb_busy),
    .arb_state     (arb_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory, who was granted last, how many
  // contested cycles the owner has used, and whether a grant just ended.
  int m_owner   = -1;
  int m_last    = 1;
  int m_overlap = 0;
  int m_run     = 0;
  bit m_rel     = 1'b0;

  // Scoreboard entries: {dev_gnt[1:0], current_slave[2:0], arb_busy}
  logic [5:0] exp_q[$];

  // Observed-grant tracker for the hold bound
  logic [1:0] obs_gnt = 2'b00;
  int         contested = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [1:0] req, input logic rst);
    int prev;
    prev  = m_owner;
    m_rel = 1'b0;
    if (!rst) begin
      m_owner   = -1;
      m_last    = 1;
      m_overlap = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || (req[1-m_owner] && m_overlap == MAX_HOLD - 1)) begin
        m_owner   = -1;
        m_overlap = 0;
        m_rel     = 1'b1;
      end else begin
        m_overlap = req[1-m_owner] ? m_overlap + 1 : 0;
      end
    end else if (req != 2'b00) begin
      if (req == 2'b11) m_owner = 1 - m_last;
      else              m_owner = req[1] ? 1 : 0;
      m_last = m_owner;
    end
    if (m_owner < 0)            m_run = 0;
    else if (m_owner == prev)   m_run = m_run + 1;
    else                        m_run = 1;
    if (m_owner < 0) exp_q.push_back({2'b00, 3'b111, 1'b0});
    else             exp_q.push_back({(m_owner == 1) ? 2'b10 : 2'b01, 3'(m_owner), 1'b1});
  endtask

  // One clock cycle: drive on the falling edge, model at the rising edge, sample 1ns later.
  task automatic step(input logic [1:0] req, input logic rst);
    logic [5:0] exp;
    arb_state_t exp_st;
    @(negedge clk);
    dev_req = req;
    rst_n   = rst;
    @(posedge clk);
    if (rst && obs_gnt != 2'b00 && req[obs_gnt[1] ? 0 : 1]) contested++;
    else contested = 0;
    model_edge(req, rst);
    #1;
    check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h0;
    if (m_owner >= 0) exp_st = GRANT;
    else if (m_rel)   exp_st = RELEASE;
    else              exp_st = IDLE;
    check("dev_gnt",       32'(dev_gnt),       32'(exp[5:4]));
    check("current_slave", 32'(current_slave), 32'(exp[3:1]));
    check("arb_busy",      32'(arb_busy),      32'(exp[0]));
    check("arb_state",     32'(arb_state),     32'(exp_st));
    check("gnt_not_11",    32'(dev_gnt == 2'b11), 32'd0);
    check("slave_consistent", 32'((current_slave == 3'b111) == (dev_gnt == 2'b00)), 32'd1);
    check("hold_bound",    32'(contested <= MAX_HOLD), 32'd1);
    obs_gnt = dev_gnt;
  endtask

  initial begin
    logic [1:0] req;

    // Reset held with both requesting
    repeat (3) step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    check("first_gnt_dev0", 32'(dev_gnt), 32'h1);
    repeat (3) step(2'b00, 1'b1);

    // Single requester: device 1 for five cycles, then idle
    repeat (5) step(2'b10, 1'b1);
    repeat (3) step(2'b00, 1'b1);

    // Alternation: each holder drops its request after three grant cycles
    for (int i = 0; i < 30; i++) begin
      req = 2'b11;
      if (m_owner >= 0 && m_run == 3) req[m_owner] = 1'b0;
      step(req, 1'b1);
    end
    repeat (3) step(2'b00, 1'b1);

    // Timeout: device 0 holds, device 1 contends, device 0 later re-granted
    repeat (2) step(2'b01, 1'b1);
    repeat (6) step(2'b11, 1'b1);
    check("preempt_to_dev1", 32'(dev_gnt), 32'h2);
    repeat (2) step(2'b11, 1'b1);
    repeat (3) step(2'b01, 1'b1);
    check("regrant_dev0", 32'(dev_gnt), 32'h1);
    repeat (2) step(2'b00, 1'b1);

    // Reset mid-grant, then a tie goes to device 0
    repeat (3) step(2'b10, 1'b1);
    step(2'b10, 1'b0);
    check("mid_reset_gnt", 32'(dev_gnt), 32'h0);
    step(2'b11, 1'b1);
    check("tie_after_reset", 32'(dev_gnt), 32'h1);
    repeat (2) step(2'b11, 1'b1);

    // Random requests with occasional resets
    for (int i = 0; i < 10000; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 63) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
